// File: rtl/maxnet_pkg.sv
// Shared constants for the four-neuron Maxnet: neuron count, winner index width
// and the controller state encoding.
package maxnet_pkg;

  localparam int NEURONS = 4;
  localparam int WIN_W   = $clog2(NEURONS);
  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_CHECK  = 3'd2;
  localparam state_t ST_UPDATE = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the Maxnet datapath: load, iterate lateral inhibition until
// the done-check reports a single survivor or the iteration limit is reached.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done_in,
  input  logic [WIN_W-1:0] sel_in,
  input  logic             all_zero,
  output logic             ld_init,
  output logic             ld_iter,
  output logic             busy,
  output logic             done,
  output logic [WIN_W-1:0] winner,
  output logic             winner_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] iter_count_reg;
  logic [WIN_W-1:0] winner_reg;
  logic             winner_valid_reg;
  logic             timeout_reg;
  logic             at_limit;

  assign at_limit = (iter_count_reg == CNT_W'(MAX_ITER));

  // Next-state decode; done_in takes priority over the iteration limit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_CHECK;
      ST_CHECK: begin
        if (done_in || at_limit) state_next = ST_FINISH;
        else                     state_next = ST_UPDATE;
      end
      ST_UPDATE: state_next = ST_CHECK;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      iter_count_reg   <= '0;
      winner_reg       <= '0;
      winner_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          // Results of the previous run survive until a new run is accepted.
          if (start) begin
            iter_count_reg   <= '0;
            winner_reg       <= '0;
            winner_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (done_in) begin
            winner_reg       <= sel_in;
            winner_valid_reg <= ~all_zero;
          end else if (at_limit) begin
            timeout_reg <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (!at_limit) iter_count_reg <= iter_count_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes are pure state decodes so no input reaches an output combinationally.
  assign ld_init      = (state_reg == ST_LOAD);
  assign ld_iter      = (state_reg == ST_UPDATE);
  assign done         = (state_reg == ST_FINISH);
  assign busy         = (state_reg != ST_IDLE);
  assign winner       = winner_reg;
  assign winner_valid = winner_valid_reg;
  assign timeout      = timeout_reg;
  assign iter_count   = iter_count_reg;

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: timeline-based reference model plus directed
// and randomized runs; the datapath is emulated by counting ld_iter commits.
module tb_maxnet_controller;

  localparam int MAX = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done_in;
  logic [1:0]    sel_in;
  logic          all_zero;
  logic          ld_init, ld_iter, busy, done, winner_valid, timeout;
  logic [1:0]    winner;
  logic [CW-1:0] iter_count;

  maxnet_controller #(.MAX_ITER(MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done_in(done_in),
    .sel_in(sel_in), .all_zero(all_zero), .ld_init(ld_init), .ld_iter(ld_iter),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plan for the next run: number of commits before a single survivor remains.
  int         p_n = 0;
  logic [1:0] p_sel = 2'd0;
  logic       p_az = 1'b0;

  // Reference model: m_k is the cycle index since acceptance (0 = idle).
  int         m_k = 0;
  int         m_n = 0;
  logic [1:0] m_sel = 2'd0;
  logic       m_az = 1'b0;
  bit         m_ran = 1'b0;

  function automatic int nit(input int n);
    return (n > MAX) ? MAX : n;
  endfunction

  function automatic int fin(input int n);
    return 3 + 2 * nit(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   <= 0;
      m_ran <= 1'b0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k   <= 1;
        m_n   <= p_n;
        m_sel <= p_sel;
        m_az  <= p_az;
        m_ran <= 1'b1;
      end
    end else if (m_k == fin(m_n)) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Datapath emulation: done_in rises once enough commits have been made.
  int         commits = 0;
  logic [1:0] noise_sel = 2'd0;
  logic       noise_az = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       commits <= 0;
    else if (ld_init) commits <= 0;
    else if (ld_iter) commits <= commits + 1;
  end

  always @(negedge clk) begin
    noise_sel <= 2'($urandom_range(0, 3));
    noise_az  <= 1'($urandom_range(0, 1));
  end

  assign done_in  = (commits >= m_n);
  assign sel_in   = done_in ? m_sel : noise_sel;
  assign all_zero = done_in ? m_az  : noise_az;

  // Per-cycle comparison against the model.
  int         e_f, e_it, e_nit;
  logic       e_show, e_to, e_v;
  logic [1:0] e_w;
  always @(negedge clk) begin
    e_f   = fin(m_n);
    e_nit = nit(m_n);
    e_to  = (m_n > MAX);
    e_w   = e_to ? 2'd0 : m_sel;
    e_v   = e_to ? 1'b0 : !m_az;
    e_show = (m_k == 0) ? m_ran : (m_k >= e_f);
    if (m_k == 0) e_it = m_ran ? e_nit : 0;
    else begin
      e_it = (m_k >= 2) ? (m_k - 2) / 2 : 0;
      if (e_it > e_nit) e_it = e_nit;
    end
    chk("ld_init", ld_init, (m_k == 1));
    chk("ld_iter", ld_iter, (m_k >= 3 && m_k <= e_f - 2 && (m_k % 2) == 1));
    chk("busy", busy, (m_k != 0));
    chk("done", done, (m_k != 0 && m_k == e_f));
    chk("iter_count", iter_count, e_it);
    chk("winner", winner, e_show ? e_w : 2'd0);
    chk("winner_valid", winner_valid, e_show ? e_v : 1'b0);
    chk("timeout", timeout, e_show ? e_to : 1'b0);
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: busy still 1 after 100 cycles, required 0");
    end
    @(negedge clk);
  endtask

  // Directed run with hand-computed expectations; leaves the bench at the done cycle.
  task automatic run_dir(input string tag, input int n, input logic [1:0] sel, input logic az,
                         input bit hold, input int x_done, input int x_iter,
                         input int x_w, input int x_v, input int x_t);
    int li = 0;
    int lit = 0;
    int dc = -1;
    @(negedge clk);
    p_n = n; p_sel = sel; p_az = az; start = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      li  += int'(ld_init);
      lit += int'(ld_iter);
      if (done) begin
        dc = i;
        break;
      end
    end
    $display("run %s: done_cycle=%0d ld_iter=%0d winner=%0d valid=%0d timeout=%0d iter=%0d",
             tag, dc, lit, winner, winner_valid, timeout, iter_count);
    chk({tag, "_done_cycle"}, dc, x_done);
    chk({tag, "_ld_init_cnt"}, li, 1);
    chk({tag, "_ld_iter_cnt"}, lit, x_iter);
    chk({tag, "_iter_count"}, iter_count, x_iter);
    chk({tag, "_winner"}, winner, x_w);
    chk({tag, "_winner_valid"}, winner_valid, x_v);
    chk({tag, "_timeout"}, timeout, x_t);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_init", ld_init, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_winner", winner, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_dir("immediate", 0, 2'd2, 1'b0, 1'b0, 3, 0, 2, 1, 0);
    wait_idle();
    run_dir("three_iter", 3, 2'd3, 1'b0, 1'b0, 9, 3, 3, 1, 0);
    wait_idle();
    run_dir("timeout", 6, 2'd1, 1'b0, 1'b0, 11, 4, 0, 0, 1);
    wait_idle();
    run_dir("at_limit", 4, 2'd1, 1'b0, 1'b0, 11, 4, 1, 1, 0);
    wait_idle();
    run_dir("all_zero", 1, 2'd0, 1'b1, 1'b0, 5, 1, 0, 0, 0);
    wait_idle();

    // start held high: no restart mid-run, new run accepted right after FINISH.
    run_dir("held_start", 3, 2'd3, 1'b0, 1'b1, 9, 3, 3, 1, 0);
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_winner_kept", winner, 3);
    chk("held_idle_iter_kept", iter_count, 3);
    @(negedge clk);
    start = 1'b0;
    chk("held_restart_ld_init", ld_init, 1);
    chk("held_restart_winner_clr", winner, 0);
    chk("held_restart_iter_clr", iter_count, 0);
    wait_idle();

    // Asynchronous reset in the second UPDATE of a long run.
    begin
      int seen = 0;
      int t = 0;
      int dones = 0;
      p_n = 10; p_sel = 2'd1; p_az = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (seen < 2 && t < 50) begin
        @(negedge clk);
        t++;
        if (ld_iter) seen++;
      end
      chk("rst_mid_reached_update", seen, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ld_iter", ld_iter, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_iter", iter_count, 0);
      chk("rst_mid_timeout", timeout, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) begin
        @(negedge clk);
        dones += int'(done);
      end
      chk("rst_mid_no_done", dones, 0);
    end

    // Randomized runs, including start noise during busy and back-to-back starts.
    repeat (900) begin
      @(negedge clk);
      if (m_k == 0 && $urandom_range(0, 3) == 0) begin
        p_n   = int'($urandom_range(0, MAX + 2));
        p_az  = ($urandom_range(0, 4) == 0);
        p_sel = p_az ? 2'd0 : 2'($urandom_range(0, 3));
      end
      start = ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
